// File: rtl/motor_output_stage.sv
// Output stage between the motor controller and the H-bridge pins.
// Adds per-channel dead time on direction changes and a bus-kicked watchdog
// that coasts the bridge and drops enable when software stops refreshing it.
module motor_output_stage #(
  parameter int unsigned F_CPU            = 16000000,
  parameter logic [7:0]  BASE_ADDRESS     = 8'h06,
  parameter logic [7:0]  DEFAULT_DEADTIME = 8'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic [7:0] address,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  input  logic [1:0] pwm_in,
  input  logic [3:0] motor_in,
  input  logic       enable_in,
  output logic [1:0] pwm_out,
  output logic [3:0] motor_out,
  output logic       enable_out
);

  localparam int unsigned CYC_PER_US = F_CPU / 1000000;
  localparam int unsigned CYC_PER_WD = F_CPU / 100;
  localparam int unsigned PW         = (CYC_PER_WD > 1) ? $clog2(CYC_PER_WD) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CYC_PER_WD - 1);

  typedef enum logic {RUN, DEAD} ch_state_t;

  // Register file and watchdog state
  logic [7:0]    deadtime_q, deadtime_d;
  logic [7:0]    wdt_reload_q, wdt_reload_d;
  logic [7:0]    dout_q, dout_d;
  logic [7:0]    wdt_cnt_q, wdt_cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          armed_q, armed_d;
  logic          fault_q, fault_d;

  // Channel state
  ch_state_t     state_q [2];
  ch_state_t     state_d [2];
  logic [1:0]    cur_q   [2];
  logic [1:0]    cur_d   [2];
  logic [1:0]    tgt_q   [2];
  logic [1:0]    tgt_d   [2];
  logic [11:0]   dcnt_q  [2];
  logic [11:0]   dcnt_d  [2];

  // Registered outputs
  logic [3:0]    motor_out_q, motor_out_d;
  logic [1:0]    pwm_out_q, pwm_out_d;
  logic          enable_out_q, enable_out_d;

  logic [8:0]    off9;
  logic          hit, wr, kick, clr, tick, expire;
  logic [1:0]    off;
  logic [1:0]    busy;
  logic [11:0]   dead_load;

  assign off9      = {1'b0, address} - {1'b0, BASE_ADDRESS};
  assign hit       = off9 < 9'd4;
  assign off       = off9[1:0];
  assign dead_load = 12'(deadtime_q * CYC_PER_US);
  assign busy[0]   = state_q[0] == DEAD;
  assign busy[1]   = state_q[1] == DEAD;

  assign dout       = dout_q;
  assign motor_out  = motor_out_q;
  assign pwm_out    = pwm_out_q;
  assign enable_out = enable_out_q;

  // Bus decode, register writes, read data and watchdog next state
  always_comb begin
    deadtime_d   = deadtime_q;
    wdt_reload_d = wdt_reload_q;
    dout_d       = dout_q;
    wr           = w_en && hit;
    kick         = wr && (off == 2'd1 || off == 2'd2);
    clr          = wr && (off == 2'd3) && din[0];

    if (wr && off == 2'd0) deadtime_d   = din;
    if (wr && off == 2'd1) wdt_reload_d = din;

    if (!hit) begin
      dout_d = '0;
    end else if (r_en) begin
      case (off)
        2'd0:    dout_d = deadtime_q;
        2'd1:    dout_d = wdt_reload_q;
        2'd2:    dout_d = '0;
        default: dout_d = {4'b0, busy[1], busy[0], 1'b0, fault_q};
      endcase
    end

    tick      = presc_q == PRE_LAST;
    presc_d   = tick ? '0 : presc_q + PW'(1);
    wdt_cnt_d = (tick && wdt_cnt_q != '0) ? wdt_cnt_q - 8'd1 : wdt_cnt_q;
    armed_d   = armed_q;
    fault_d   = fault_q;
    // Expiry is one-shot (armed clears), so a later clear is not re-faulted
    // by a counter parked at zero. A clear colliding with expiry loses and
    // does not reload.
    expire    = armed_q && wdt_cnt_q == '0;

    if (expire && !kick) begin
      fault_d = 1'b1;
      armed_d = 1'b0;
    end else if (clr) begin
      fault_d = 1'b0;
    end

    if (kick || (clr && !expire)) begin
      presc_d   = '0;
      wdt_cnt_d = wdt_reload_d;
      armed_d   = wdt_reload_d != '0;
    end
  end

  // Per-channel dead-time FSM and gated outputs
  always_comb begin
    motor_out_d  = '0;
    pwm_out_d    = '0;
    enable_out_d = enable_in && !fault_d;
    for (int unsigned i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cur_d[i]   = cur_q[i];
      tgt_d[i]   = tgt_q[i];
      dcnt_d[i]  = dcnt_q[i];
      if (fault_d) begin
        state_d[i] = RUN;
        cur_d[i]   = 2'b00;
        tgt_d[i]   = 2'b00;
        dcnt_d[i]  = '0;
      end else begin
        case (state_q[i])
          RUN: begin
            if (motor_in[2*i +: 2] != cur_q[i]) begin
              if (deadtime_q == '0) begin
                cur_d[i] = motor_in[2*i +: 2];
              end else begin
                state_d[i] = DEAD;
                tgt_d[i]   = motor_in[2*i +: 2];
                dcnt_d[i]  = dead_load;
              end
            end
          end
          default: begin
            if (motor_in[2*i +: 2] != tgt_q[i]) begin
              if (deadtime_q == '0) begin
                state_d[i] = RUN;
                cur_d[i]   = motor_in[2*i +: 2];
              end else begin
                tgt_d[i]  = motor_in[2*i +: 2];
                dcnt_d[i] = dead_load;
              end
            end else if (dcnt_q[i] <= 12'd1) begin
              state_d[i] = RUN;
              cur_d[i]   = motor_in[2*i +: 2];
            end else begin
              dcnt_d[i] = dcnt_q[i] - 12'd1;
            end
          end
        endcase
      end
      motor_out_d[2*i +: 2] = (state_d[i] == RUN) ? cur_d[i] : 2'b00;
      pwm_out_d[i]          = (state_d[i] == RUN) && pwm_in[i] && !fault_d;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deadtime_q   <= DEFAULT_DEADTIME;
      wdt_reload_q <= '0;
      dout_q       <= '0;
      wdt_cnt_q    <= '0;
      presc_q      <= '0;
      armed_q      <= 1'b0;
      fault_q      <= 1'b0;
      motor_out_q  <= '0;
      pwm_out_q    <= '0;
      enable_out_q <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        state_q[i] <= RUN;
        cur_q[i]   <= 2'b00;
        tgt_q[i]   <= 2'b00;
        dcnt_q[i]  <= '0;
      end
    end else begin
      deadtime_q   <= deadtime_d;
      wdt_reload_q <= wdt_reload_d;
      dout_q       <= dout_d;
      wdt_cnt_q    <= wdt_cnt_d;
      presc_q      <= presc_d;
      armed_q      <= armed_d;
      fault_q      <= fault_d;
      motor_out_q  <= motor_out_d;
      pwm_out_q    <= pwm_out_d;
      enable_out_q <= enable_out_d;
      state_q      <= state_d;
      cur_q        <= cur_d;
      tgt_q        <= tgt_d;
      dcnt_q       <= dcnt_d;
    end
  end

endmodule
